// File: rtl/cpu_bus_bridge_if.sv
// cpu_bus_bridge_if: CPU strobe bus plus peripheral req/ack bus seen by the bridge
interface cpu_bus_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_bus_clk;
  logic              cpu_bus_we;
  logic [ADDR_W-1:0] cpu_bus_addr;
  logic [DATA_W-1:0] cpu_bus_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_data_ready;
  logic              per_req;
  logic              per_we;
  logic [ADDR_W-1:0] per_addr;
  logic [DATA_W-1:0] per_wdata;
  logic              per_ack;
  logic [DATA_W-1:0] per_rdata;
  logic              busy;
  logic              timeout_err;
  logic              overrun_err;
  modport slave (
    input  cpu_bus_clk, cpu_bus_we, cpu_bus_addr, cpu_bus_wdata, per_ack, per_rdata,
    output cpu_rdata, cpu_data_ready, per_req, per_we, per_addr, per_wdata,
           busy, timeout_err, overrun_err
  );
  modport master (
    output cpu_bus_clk, cpu_bus_we, cpu_bus_addr, cpu_bus_wdata, per_ack, per_rdata,
    input  cpu_rdata, cpu_data_ready, per_req, per_we, per_addr, per_wdata,
           busy, timeout_err, overrun_err
  );
endinterface

// File: rtl/cpu_bus_bridge.sv
// cpu_bus_bridge: CPU strobe edges to peripheral req/ack with one-deep buffer, timeout and sticky errors
module cpu_bus_bridge #(
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter int                TIMEOUT_CYCLES = 16,
  parameter logic [DATA_W-1:0] TIMEOUT_DATA   = 32'hDEADBEEF
) (
  input logic             clk,
  input logic             rst,
  cpu_bus_bridge_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  state_t            state, state_nx;
  logic              strb_q, strb_edge;
  logic [7:0]        cnt;
  logic              pend_v, pend_we;
  logic [ADDR_W-1:0] pend_addr, act_addr;
  logic [DATA_W-1:0] pend_wdata, act_wdata, rdata;
  logic              act_we, timeout_err, overrun_err;
  logic              ack, tmo, load_pend, load_edge, to_pend, overrun;
  // a buffered request is drained from IDLE as well as DONE, since an edge in DONE may fill it
  always_comb begin
    strb_edge = bus.cpu_bus_clk & ~strb_q;
    ack       = (state == BUSY) && bus.per_ack;
    tmo       = (state == BUSY) && !bus.per_ack && (cnt == TMO_LAST);
    load_pend = pend_v && (state == IDLE || state == DONE);
    load_edge = strb_edge && (state == IDLE) && !pend_v;
    to_pend   = strb_edge && !load_edge && (!pend_v || state == IDLE);
    overrun   = strb_edge && !load_edge && !to_pend;
    state_nx  = (state == IDLE) ? ((pend_v || strb_edge) ? BUSY : IDLE)
              : (state == BUSY) ? ((ack || tmo) ? DONE : BUSY)
              : (pend_v ? BUSY : IDLE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      strb_q      <= 1'b0;
      cnt         <= 8'd0;
      pend_v      <= 1'b0;
      pend_we     <= 1'b0;
      pend_addr   <= '0;
      pend_wdata  <= '0;
      act_we      <= 1'b0;
      act_addr    <= '0;
      act_wdata   <= '0;
      rdata       <= '0;
      timeout_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      state  <= state_nx;
      strb_q <= bus.cpu_bus_clk;
      cnt    <= (state == BUSY) ? cnt + 8'd1 : 8'd0;
      if (load_pend) {act_we, act_addr, act_wdata} <= {pend_we, pend_addr, pend_wdata};
      else if (load_edge) {act_we, act_addr, act_wdata} <= {bus.cpu_bus_we, bus.cpu_bus_addr, bus.cpu_bus_wdata};
      pend_v <= to_pend | (pend_v & ~load_pend);
      if (to_pend) {pend_we, pend_addr, pend_wdata} <= {bus.cpu_bus_we, bus.cpu_bus_addr, bus.cpu_bus_wdata};
      if (!act_we && (ack || tmo)) rdata <= ack ? bus.per_rdata : TIMEOUT_DATA;
      if (tmo) timeout_err <= 1'b1;
      if (overrun) overrun_err <= 1'b1;
    end
  end
  assign bus.per_req        = (state == BUSY);
  assign bus.cpu_data_ready = (state == DONE);
  assign bus.per_we         = act_we;
  assign bus.per_addr       = act_addr;
  assign bus.per_wdata      = act_wdata;
  assign bus.cpu_rdata      = rdata;
  assign bus.busy           = (state != IDLE) || pend_v;
  assign bus.timeout_err    = timeout_err;
  assign bus.overrun_err    = overrun_err;
endmodule

// File: tb/tb_cpu_bus_bridge.sv
// tb_cpu_bus_bridge: scenario tasks plus randomized transactions against a transaction-level model
module tb_cpu_bus_bridge;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  cpu_bus_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus();
  cpu_bus_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16), .TIMEOUT_DATA(32'hDEADBEEF))
    dut (.clk(clk), .rst(rst), .bus(bus));
  localparam logic [31:0] TDATA = 32'hDEADBEEF;
  int n_cmp = 0, n_bad = 0;
  int delay = 255;
  logic [31:0] key = 32'h0;
  logic stray = 1'b0;
  int rcyc = 0;
  int ready_cnt = 0, req_cnt = 0, stab_bad = 0;
  logic prev_req = 1'b0;
  logic [31:0] log_addr[$];
  logic [31:0] log_wdata[$];
  logic        log_we[$];
  // peripheral model: acks after `delay` request cycles, read data derived from the address
  always @(posedge clk) begin
    #1;
    bus.per_ack   = (bus.per_req && rcyc == delay) || stray;
    bus.per_rdata = bus.per_addr ^ key;
    rcyc = bus.per_req ? rcyc + 1 : 0;
  end
  always @(negedge clk) begin
    if (bus.cpu_data_ready) ready_cnt++;
    if (bus.per_req) begin
      req_cnt++;
      if (!prev_req) begin
        log_addr.push_back(bus.per_addr);
        log_we.push_back(bus.per_we);
        log_wdata.push_back(bus.per_wdata);
      end else if (bus.per_addr !== log_addr[$] || bus.per_we !== log_we[$] || bus.per_wdata !== log_wdata[$])
        stab_bad++;
    end
    prev_req = bus.per_req;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata, output int lat);
    bus.cpu_bus_clk   = 1'b1;
    bus.cpu_bus_we    = we;
    bus.cpu_bus_addr  = addr;
    bus.cpu_bus_wdata = wdata;
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      tick();
      bus.cpu_bus_clk = 1'b0;
      if (bus.cpu_data_ready) begin
        lat = i;
        break;
      end
    end
  endtask
  task automatic test_reset();
    repeat (3) tick();
    n_cmp++; if (bus.per_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", bus.per_req); end
    n_cmp++; if (bus.cpu_data_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", bus.cpu_data_ready); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_cmp++; if ({bus.timeout_err, bus.overrun_err} !== 2'b00) begin n_bad++; $display("FAIL reset_flags: got %b want 00", {bus.timeout_err, bus.overrun_err}); end
    n_cmp++; if (bus.cpu_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", bus.cpu_rdata); end
    n_cmp++; if ({bus.per_we, bus.per_addr, bus.per_wdata} !== 65'h0) begin n_bad++; $display("FAIL reset_per: got %h want 0", {bus.per_we, bus.per_addr, bus.per_wdata}); end
    rst = 1'b0;
    tick();
  endtask
  task automatic test_read_ack();
    int lat, r0, q0;
    logic [31:0] a;
    a = $urandom; key = a ^ 32'h12345678; delay = 3; r0 = ready_cnt; q0 = req_cnt;
    do_txn(1'b0, a, $urandom, lat);
    repeat (4) tick();
    n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL read_latency: got %0d want 5", lat); end
    n_cmp++; if (bus.cpu_rdata !== 32'h12345678) begin n_bad++; $display("FAIL read_rdata: got %h want 12345678", bus.cpu_rdata); end
    n_cmp++; if (req_cnt - q0 !== 4) begin n_bad++; $display("FAIL read_req_cycles: got %0d want 4", req_cnt - q0); end
    n_cmp++; if (ready_cnt - r0 !== 1) begin n_bad++; $display("FAIL read_pulses: got %0d want 1", ready_cnt - r0); end
    n_cmp++; if (log_addr[$] !== a || stab_bad !== 0) begin n_bad++; $display("FAIL read_addr: got %h unstable %0d want %h", log_addr[$], stab_bad, a); end
  endtask
  task automatic test_write();
    int lat;
    delay = 0;
    do_txn(1'b1, 32'h0000_F000, 32'hA5A5A5A5, lat);
    tick();
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL write_latency: got %0d want 2", lat); end
    n_cmp++; if ({log_we[$], log_addr[$], log_wdata[$]} !== {1'b1, 32'h0000_F000, 32'hA5A5A5A5}) begin n_bad++; $display("FAIL write_per: got %b %h %h want 1 0000f000 a5a5a5a5", log_we[$], log_addr[$], log_wdata[$]); end
    n_cmp++; if (bus.cpu_rdata !== 32'h12345678) begin n_bad++; $display("FAIL write_rdata_kept: got %h want 12345678", bus.cpu_rdata); end
  endtask
  task automatic test_ack_at_timeout();
    int lat, q0;
    logic [31:0] a;
    a = $urandom; key = $urandom; delay = 15; q0 = req_cnt;
    do_txn(1'b0, a, 32'h0, lat);
    tick();
    n_cmp++; if (lat !== 17) begin n_bad++; $display("FAIL edge_ack_latency: got %0d want 17", lat); end
    n_cmp++; if (bus.cpu_rdata !== (a ^ key)) begin n_bad++; $display("FAIL edge_ack_rdata: got %h want %h", bus.cpu_rdata, a ^ key); end
    n_cmp++; if (bus.timeout_err !== 1'b0) begin n_bad++; $display("FAIL edge_ack_timeout_err: got %b want 0", bus.timeout_err); end
    n_cmp++; if (req_cnt - q0 !== 16) begin n_bad++; $display("FAIL edge_ack_req_cycles: got %0d want 16", req_cnt - q0); end
  endtask
  task automatic test_timeout();
    int lat, q0, r0;
    delay = 255; q0 = req_cnt;
    do_txn(1'b0, $urandom, 32'h0, lat);
    tick();
    n_cmp++; if (lat !== 17) begin n_bad++; $display("FAIL timeout_latency: got %0d want 17", lat); end
    n_cmp++; if (req_cnt - q0 !== 16) begin n_bad++; $display("FAIL timeout_req_cycles: got %0d want 16", req_cnt - q0); end
    n_cmp++; if (bus.cpu_rdata !== TDATA) begin n_bad++; $display("FAIL timeout_rdata: got %h want %h", bus.cpu_rdata, TDATA); end
    n_cmp++; if (bus.timeout_err !== 1'b1) begin n_bad++; $display("FAIL timeout_flag: got %b want 1", bus.timeout_err); end
    r0 = ready_cnt; key = 32'h0BAD0BAD; stray = 1'b1;
    repeat (2) tick();
    stray = 1'b0;
    repeat (3) tick();
    n_cmp++; if (ready_cnt !== r0 || bus.per_req !== 1'b0) begin n_bad++; $display("FAIL stray_ack_activity: got pulses %0d req %b want 0 0", ready_cnt - r0, bus.per_req); end
    n_cmp++; if (bus.cpu_rdata !== TDATA || bus.timeout_err !== 1'b1) begin n_bad++; $display("FAIL stray_ack_state: got %h %b want %h 1", bus.cpu_rdata, bus.timeout_err, TDATA); end
  endtask
  task automatic test_back_to_back();
    int r0, l0;
    logic [31:0] a1, a2, a3;
    a1 = $urandom; a2 = $urandom; a3 = $urandom; key = $urandom; delay = 5;
    r0 = ready_cnt; l0 = log_addr.size();
    bus.cpu_bus_we = 1'b0;
    bus.cpu_bus_clk = 1'b1; bus.cpu_bus_addr = a1; tick();
    bus.cpu_bus_clk = 1'b0; tick();
    bus.cpu_bus_clk = 1'b1; bus.cpu_bus_addr = a2; tick();
    bus.cpu_bus_clk = 1'b0; tick();
    bus.cpu_bus_clk = 1'b1; bus.cpu_bus_addr = a3; tick();
    bus.cpu_bus_clk = 1'b0;
    repeat (25) tick();
    n_cmp++; if (ready_cnt - r0 !== 2) begin n_bad++; $display("FAIL b2b_pulses: got %0d want 2", ready_cnt - r0); end
    n_cmp++; if (log_addr.size() !== l0 + 2) begin n_bad++; $display("FAIL b2b_req_count: got %0d want 2", log_addr.size() - l0); end
    else begin
      n_cmp++; if (log_addr[l0] !== a1 || log_addr[l0+1] !== a2) begin n_bad++; $display("FAIL b2b_order: got %h %h want %h %h", log_addr[l0], log_addr[l0+1], a1, a2); end
    end
    n_cmp++; if (bus.overrun_err !== 1'b1 || bus.timeout_err !== 1'b1) begin n_bad++; $display("FAIL b2b_flags: got ovr %b to %b want 1 1", bus.overrun_err, bus.timeout_err); end
    n_cmp++; if (bus.cpu_rdata !== (a2 ^ key)) begin n_bad++; $display("FAIL b2b_rdata: got %h want %h", bus.cpu_rdata, a2 ^ key); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL b2b_idle: got busy %b want 0", bus.busy); end
  endtask
  task automatic test_reset_mid_busy();
    int r0, q0, lat;
    logic [31:0] a;
    delay = 255; r0 = ready_cnt;
    bus.cpu_bus_we = 1'b0;
    bus.cpu_bus_clk = 1'b1; bus.cpu_bus_addr = $urandom; tick();
    bus.cpu_bus_clk = 1'b0; tick();
    bus.cpu_bus_clk = 1'b1; bus.cpu_bus_addr = $urandom; tick();
    bus.cpu_bus_clk = 1'b0; tick();
    n_cmp++; if (bus.per_req !== 1'b1 || bus.busy !== 1'b1) begin n_bad++; $display("FAIL rst_pre_busy: got req %b busy %b want 1 1", bus.per_req, bus.busy); end
    rst = 1'b1; tick(); rst = 1'b0;
    n_cmp++; if (bus.per_req !== 1'b0 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_abort: got req %b busy %b want 0 0", bus.per_req, bus.busy); end
    n_cmp++; if ({bus.timeout_err, bus.overrun_err} !== 2'b00 || bus.cpu_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_clear: got flags %b rdata %h want 00 0", {bus.timeout_err, bus.overrun_err}, bus.cpu_rdata); end
    q0 = req_cnt;
    repeat (25) tick();
    n_cmp++; if (ready_cnt !== r0 || req_cnt !== q0) begin n_bad++; $display("FAIL rst_quiet: got pulses %0d req cycles %0d want 0 0", ready_cnt - r0, req_cnt - q0); end
    a = $urandom; key = $urandom; delay = 0;
    do_txn(1'b0, a, 32'h0, lat);
    tick();
    n_cmp++; if (lat !== 2 || bus.cpu_rdata !== (a ^ key)) begin n_bad++; $display("FAIL rst_recover: got lat %0d rdata %h want 2 %h", lat, bus.cpu_rdata, a ^ key); end
  endtask
  task automatic test_random();
    int lat, d, exp_lat;
    logic we, exp_to;
    logic [31:0] a, w, exp_rd;
    exp_rd = bus.cpu_rdata == bus.cpu_rdata ? (log_addr[$] ^ key) : 32'h0;
    exp_to = 1'b0;
    for (int i = 0; i < 24; i++) begin
      we = 1'($urandom_range(0, 1)); a = $urandom; w = $urandom; d = $urandom_range(0, 20);
      delay = d; key = $urandom;
      do_txn(we, a, w, lat);
      tick();
      exp_lat = (d < 16) ? d + 2 : 17;
      if (!we) exp_rd = (d < 16) ? (a ^ key) : TDATA;
      exp_to = exp_to | (d >= 16);
      n_cmp++; if (lat !== exp_lat) begin n_bad++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, lat, exp_lat); end
      n_cmp++; if (bus.cpu_rdata !== exp_rd) begin n_bad++; $display("FAIL rnd%0d_rdata: got %h want %h", i, bus.cpu_rdata, exp_rd); end
      n_cmp++; if (bus.timeout_err !== exp_to) begin n_bad++; $display("FAIL rnd%0d_timeout_err: got %b want %b", i, bus.timeout_err, exp_to); end
      n_cmp++; if ({log_we[$], log_addr[$], log_wdata[$]} !== {we, a, w}) begin n_bad++; $display("FAIL rnd%0d_per: got %b %h %h want %b %h %h", i, log_we[$], log_addr[$], log_wdata[$], we, a, w); end
    end
    n_cmp++; if (stab_bad !== 0) begin n_bad++; $display("FAIL per_stability: got %0d changes want 0", stab_bad); end
  endtask
  initial begin
    bus.cpu_bus_clk = 1'b0; bus.cpu_bus_we = 1'b0; bus.cpu_bus_addr = 32'h0; bus.cpu_bus_wdata = 32'h0;
    test_reset();
    test_read_ack();
    test_write();
    test_ack_at_timeout();
    test_timeout();
    test_back_to_back();
    test_reset_mid_busy();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
